// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit to data path signal bundle
interface control_unit_if;
   logic [7:0] IR;
   logic [3:0] CCR_Result;
   logic       IR_Load;
   logic       MAR_Load;
   logic       PC_Load;
   logic       PC_Inc;
   logic       A_Load;
   logic       B_Load;
   logic       CCR_Load;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel;
   logic [1:0] Bus2_Sel;
   logic       write;

   modport master (
      input  IR, CCR_Result,
      output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
      output ALU_Sel, Bus1_Sel, Bus2_Sel, write
   );

   modport slave (
      output IR, CCR_Result,
      input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
      input  ALU_Sel, Bus1_Sel, Bus2_Sel, write
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore FSM sequencing fetch/decode/execute for the data path
module control_unit (
   input  logic               Clk,
   input  logic               Reset,
   control_unit_if.master     bus,
   output logic [4:0]         state
);
   localparam logic [4:0] S_F0       = 5'd0;
   localparam logic [4:0] S_F1       = 5'd1;
   localparam logic [4:0] S_F2       = 5'd2;
   localparam logic [4:0] S_DEC      = 5'd3;
   localparam logic [4:0] S_LS_E0    = 5'd4;   // load/store operand fetch: MAR <- PC
   localparam logic [4:0] S_LS_E1    = 5'd5;   // load/store: step PC past operand
   localparam logic [4:0] S_LDA_IMM  = 5'd6;
   localparam logic [4:0] S_LDB_IMM  = 5'd7;
   localparam logic [4:0] S_DIR_E2   = 5'd8;   // MAR <- operand address (loads and stores)
   localparam logic [4:0] S_LD_E3    = 5'd9;   // memory read latency
   localparam logic [4:0] S_LDA_DIR  = 5'd10;
   localparam logic [4:0] S_LDB_DIR  = 5'd11;
   localparam logic [4:0] S_STA      = 5'd12;
   localparam logic [4:0] S_STB      = 5'd13;
   localparam logic [4:0] S_ADD      = 5'd14;
   localparam logic [4:0] S_SUB      = 5'd15;
   localparam logic [4:0] S_AND      = 5'd16;
   localparam logic [4:0] S_OR       = 5'd17;
   localparam logic [4:0] S_NOT      = 5'd18;
   localparam logic [4:0] S_BR_E0    = 5'd19;
   localparam logic [4:0] S_BR_E1    = 5'd20;
   localparam logic [4:0] S_BR_E2    = 5'd21;
   localparam logic [4:0] S_BRN_E0   = 5'd22;

   logic [4:0] state_q;
   logic [4:0] state_d;
   logic       flag_z;
   logic       flag_c;

   assign state  = state_q;
   assign flag_z = bus.CCR_Result[2];
   assign flag_c = bus.CCR_Result[0];

   // Next-state selection; execute paths share states while the opcode (stable in IR) picks the branch points.
   always_comb begin
      state_d = S_F0;
      case (state_q)
         S_F0:      state_d = S_F1;
         S_F1:      state_d = S_F2;
         S_F2:      state_d = S_DEC;
         S_DEC: begin
            case (bus.IR)
               8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97: state_d = S_LS_E0;
               8'h42:   state_d = S_ADD;
               8'h43:   state_d = S_SUB;
               8'h44:   state_d = S_AND;
               8'h45:   state_d = S_OR;
               8'h46:   state_d = S_NOT;
               8'h20:   state_d = S_BR_E0;
               8'h23:   state_d = flag_z  ? S_BR_E0 : S_BRN_E0;
               8'h24:   state_d = !flag_z ? S_BR_E0 : S_BRN_E0;
               8'h27:   state_d = flag_c  ? S_BR_E0 : S_BRN_E0;
               default: state_d = S_F0;
            endcase
         end
         S_LS_E0:   state_d = S_LS_E1;
         S_LS_E1: begin
            case (bus.IR)
               8'h86:   state_d = S_LDA_IMM;
               8'h88:   state_d = S_LDB_IMM;
               default: state_d = S_DIR_E2;
            endcase
         end
         S_DIR_E2: begin
            case (bus.IR)
               8'h96:   state_d = S_STA;
               8'h97:   state_d = S_STB;
               default: state_d = S_LD_E3;
            endcase
         end
         S_LD_E3:   state_d = (bus.IR == 8'h87) ? S_LDA_DIR : S_LDB_DIR;
         S_BR_E0:   state_d = S_BR_E1;
         S_BR_E1:   state_d = S_BR_E2;
         default:   state_d = S_F0;
      endcase
   end

   // Moore output decode from the current state, all forced low while Reset is high.
   always_comb begin
      bus.IR_Load  = 1'b0;
      bus.MAR_Load = 1'b0;
      bus.PC_Load  = 1'b0;
      bus.PC_Inc   = 1'b0;
      bus.A_Load   = 1'b0;
      bus.B_Load   = 1'b0;
      bus.CCR_Load = 1'b0;
      bus.ALU_Sel  = 3'b000;
      bus.Bus1_Sel = 2'b00;
      bus.Bus2_Sel = 2'b00;
      bus.write    = 1'b0;
      if (!Reset) begin
         case (state_q)
            S_F0, S_LS_E0, S_BR_E0: begin
               bus.Bus1_Sel = 2'b00;
               bus.Bus2_Sel = 2'b01;
               bus.MAR_Load = 1'b1;
            end
            S_F1, S_LS_E1, S_BRN_E0: bus.PC_Inc = 1'b1;
            S_F2: begin
               bus.Bus2_Sel = 2'b10;
               bus.IR_Load  = 1'b1;
            end
            S_LDA_IMM, S_LDA_DIR: begin
               bus.Bus2_Sel = 2'b10;
               bus.A_Load   = 1'b1;
            end
            S_LDB_IMM, S_LDB_DIR: begin
               bus.Bus2_Sel = 2'b10;
               bus.B_Load   = 1'b1;
            end
            S_DIR_E2: begin
               bus.Bus2_Sel = 2'b10;
               bus.MAR_Load = 1'b1;
            end
            S_STA: begin
               bus.Bus1_Sel = 2'b01;
               bus.write    = 1'b1;
            end
            S_STB: begin
               bus.Bus1_Sel = 2'b10;
               bus.write    = 1'b1;
            end
            S_ADD, S_SUB, S_AND, S_OR, S_NOT: begin
               bus.Bus1_Sel = 2'b10;
               bus.Bus2_Sel = 2'b00;
               bus.A_Load   = 1'b1;
               bus.CCR_Load = 1'b1;
               case (state_q)
                  S_SUB:   bus.ALU_Sel = 3'b010;
                  S_AND:   bus.ALU_Sel = 3'b011;
                  S_OR:    bus.ALU_Sel = 3'b001;
                  S_NOT:   bus.ALU_Sel = 3'b111;
                  default: bus.ALU_Sel = 3'b000;
               endcase
            end
            S_BR_E2: begin
               bus.Bus2_Sel = 2'b10;
               bus.PC_Load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State register; Reset returns to F0 from anywhere, including mid-instruction.
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_F0;
      else       state_q <= state_d;
   end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;
   logic       Clk = 1'b0;
   logic       Reset;
   logic [4:0] state;

   control_unit_if bus ();

   control_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus),
      .state (state)
   );

   always #5 Clk = ~Clk;

   // ctrl vector: {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, ALU_Sel, Bus1_Sel, Bus2_Sel, write}
   localparam logic [14:0] IRL   = 15'h4000;
   localparam logic [14:0] MARL  = 15'h2000;
   localparam logic [14:0] PCL   = 15'h1000;
   localparam logic [14:0] PCI   = 15'h0800;
   localparam logic [14:0] AL    = 15'h0400;
   localparam logic [14:0] BL    = 15'h0200;
   localparam logic [14:0] CCRL  = 15'h0100;
   localparam logic [14:0] A_OR  = 15'h0020;
   localparam logic [14:0] A_SUB = 15'h0040;
   localparam logic [14:0] A_AND = 15'h0060;
   localparam logic [14:0] A_NOT = 15'h00E0;
   localparam logic [14:0] B1_A  = 15'h0008;
   localparam logic [14:0] B1_B  = 15'h0010;
   localparam logic [14:0] B2_B1 = 15'h0002;
   localparam logic [14:0] B2_M  = 15'h0004;
   localparam logic [14:0] WR    = 15'h0001;
   localparam logic [14:0] NONE  = 15'h0000;

   localparam logic [14:0] V_MAR_PC = MARL | B2_B1;
   localparam logic [14:0] V_F2     = IRL | B2_M;
   localparam logic [14:0] V_MAR_M  = MARL | B2_M;
   localparam logic [14:0] V_ALU    = B1_B | AL | CCRL;

   typedef struct {
      logic        chk_state;
      logic [14:0] ctrl;
      logic [7:0]  op;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [14:0] act;
   assign act = {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load, bus.B_Load,
                 bus.CCR_Load, bus.ALU_Sel, bus.Bus1_Sel, bus.Bus2_Sel, bus.write};

   // Monitor: one expected entry per cycle, compared at the falling edge.
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (act !== e.ctrl || (e.chk_state && state !== 5'd0)) begin
            errors++;
            $display("FAIL op%h_cyc%0d ctrl actual=%h required=%h state actual=%0d (required 0: %0b)",
                     e.op, e.cyc, act, e.ctrl, state, e.chk_state);
         end
      end
   end

   task automatic push(input logic [7:0] op, input int cyc, input logic chk, input logic [14:0] c);
      exp_t e;
      e.op = op; e.cyc = cyc; e.chk_state = chk; e.ctrl = c;
      sb.push_back(e);
   endtask

   task automatic push_fetch(input logic [7:0] op);
      push(op, 1, 1'b1, V_MAR_PC);
      push(op, 2, 1'b0, PCI);
      push(op, 3, 1'b0, V_F2);
      push(op, 4, 1'b0, NONE);
   endtask

   task automatic run(input logic [7:0] op, input logic [3:0] ccr, input int n,
                      input logic [14:0] t0, input logic [14:0] t1, input logic [14:0] t2,
                      input logic [14:0] t3, input logic [14:0] t4);
      logic [14:0] t [5];
      t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3; t[4] = t4;
      bus.IR = op;
      bus.CCR_Result = ccr;
      push_fetch(op);
      for (int i = 0; i < n; i++) push(op, 5 + i, 1'b0, t[i]);
      repeat (4 + n) @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      bus.IR = 8'h00;
      bus.CCR_Result = 4'h0;
      @(posedge Clk); #1;
      push(8'h00, 0, 1'b1, NONE);
      @(posedge Clk); #1;
      Reset = 1'b0;

      run(8'h86, 4'h0, 3, V_MAR_PC, PCI, B2_M | AL, NONE, NONE);
      run(8'h88, 4'h0, 3, V_MAR_PC, PCI, B2_M | BL, NONE, NONE);
      run(8'h87, 4'h0, 5, V_MAR_PC, PCI, V_MAR_M, NONE, B2_M | AL);
      run(8'h89, 4'h0, 5, V_MAR_PC, PCI, V_MAR_M, NONE, B2_M | BL);
      run(8'h96, 4'h0, 4, V_MAR_PC, PCI, V_MAR_M, B1_A | WR, NONE);
      run(8'h97, 4'h0, 4, V_MAR_PC, PCI, V_MAR_M, B1_B | WR, NONE);
      run(8'h42, 4'h0, 1, V_ALU, NONE, NONE, NONE, NONE);
      run(8'h43, 4'h0, 1, V_ALU | A_SUB, NONE, NONE, NONE, NONE);
      run(8'h44, 4'h0, 1, V_ALU | A_AND, NONE, NONE, NONE, NONE);
      run(8'h45, 4'h0, 1, V_ALU | A_OR, NONE, NONE, NONE, NONE);
      run(8'h46, 4'h0, 1, V_ALU | A_NOT, NONE, NONE, NONE, NONE);
      run(8'h20, 4'h0, 3, V_MAR_PC, NONE, B2_M | PCL, NONE, NONE);
      run(8'h23, 4'b0100, 3, V_MAR_PC, NONE, B2_M | PCL, NONE, NONE);
      run(8'h23, 4'b0000, 1, PCI, NONE, NONE, NONE, NONE);
      run(8'h24, 4'b0000, 3, V_MAR_PC, NONE, B2_M | PCL, NONE, NONE);
      run(8'h24, 4'b0100, 1, PCI, NONE, NONE, NONE, NONE);
      run(8'h27, 4'b0001, 3, V_MAR_PC, NONE, B2_M | PCL, NONE, NONE);
      run(8'h27, 4'b1110, 1, PCI, NONE, NONE, NONE, NONE);
      run(8'hFF, 4'hF, 0, NONE, NONE, NONE, NONE, NONE);

      // LDA_DIR interrupted by Reset during E3: the E4 cycle must show no A_Load and state 0
      bus.IR = 8'h87;
      bus.CCR_Result = 4'h0;
      push_fetch(8'h87);
      push(8'h87, 5, 1'b0, V_MAR_PC);
      push(8'h87, 6, 1'b0, PCI);
      push(8'h87, 7, 1'b0, V_MAR_M);
      push(8'h87, 8, 1'b0, NONE);
      repeat (7) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      push(8'h87, 9, 1'b1, NONE);
      @(posedge Clk); #1;
      Reset = 1'b0;

      run(8'h87, 4'h0, 5, V_MAR_PC, PCI, V_MAR_M, NONE, B2_M | AL);
      bus.IR = 8'h00;
      push(8'h00, 1, 1'b1, V_MAR_PC);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
